// File: rtl/alu_uart_interface.sv
// Byte-serial front-end for the ALU: collects A, B and opcode from the UART receiver,
// then hands the ALU result to the UART transmitter. Optional macro: ALU_IF_OPCODE_CHECK_EN.
module alu_uart_interface #(
    parameter int                 NB_DATA  = 8,
    parameter int                 NB_OP    = 6,
    parameter logic [NB_DATA-1:0] ERR_CODE = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic               rx_done,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done,
    output logic [NB_DATA-1:0] dato_a,
    output logic [NB_DATA-1:0] dato_b,
    output logic [NB_OP-1:0]   opcode,
    output logic [NB_DATA-1:0] tx_data,
    output logic               tx_start,
    output logic               busy
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        WAIT_TX
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               load_a;
    logic               load_b;
    logic               load_op;
    logic               load_tx;
    logic [NB_DATA-1:0] tx_byte;

    // Only the low NB_OP bits of the opcode byte carry meaning.
    logic [NB_DATA-NB_OP-1:0] unused_rx_hi;
    assign unused_rx_hi = rx_data[NB_DATA-1:NB_OP];

`ifdef ALU_IF_OPCODE_CHECK_EN
    function automatic logic opcode_ok(input logic [NB_OP-1:0] op);
        case (op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
            NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
                opcode_ok = 1'b1;
            default:
                opcode_ok = 1'b0;
        endcase
    endfunction

    // The opcode register still holds a rejected value; only the reply byte changes.
    assign tx_byte = opcode_ok(opcode) ? alu_result : ERR_CODE;
`else
    logic [NB_DATA-1:0] unused_err_code;
    assign unused_err_code = ERR_CODE;
    assign tx_byte         = alu_result;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_tx    = 1'b0;
        case (state)
            WAIT_A: begin
                if (rx_done) begin
                    load_a     = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done) begin
                    load_b     = 1'b1;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (rx_done) begin
                    load_op    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                load_tx    = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dato_a   <= '0;
            dato_b   <= '0;
            opcode   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
        end else begin
            if (load_a)  dato_a  <= rx_data;
            if (load_b)  dato_b  <= rx_data;
            if (load_op) opcode  <= rx_data[NB_OP-1:0];
            if (load_tx) tx_data <= tx_byte;
            // EXEC lasts one cycle, so this is a single-cycle pulse.
            tx_start <= load_tx;
        end
    end

    assign busy = (state == EXEC) || (state == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface: directed vector table, hand-written
// corner sequences and randomized sequences against a byte-level reference model.
module tb_alu_uart_interface;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] alu_result;
    logic       tx_done;
    logic [7:0] dato_a;
    logic [7:0] dato_b;
    logic [5:0] opcode;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_uart_interface dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .alu_result (alu_result),
        .tx_done    (tx_done),
        .dato_a     (dato_a),
        .dato_b     (dato_b),
        .opcode     (opcode),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU the block drives; unknown opcodes give a recognisable pattern.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000011: return sa >>> b;
            6'b000010: return a >> b;
            default:   return {a[3:0], b[3:0]};
        endcase
    endfunction

    assign alu_result = alu_fn(dato_a, dato_b, opcode);

    logic [5:0] valid_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    function automatic bit is_valid(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: the reply byte is decided only by the three bytes sent.
    function automatic logic [7:0] expected_reply(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] opb);
`ifdef ALU_IF_OPCODE_CHECK_EN
        if (!is_valid(opb[5:0])) return 8'hFF;
`endif
        return alu_fn(a, b, opb[5:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Sends A, B, opcode with optional idle gaps; returns during the EXEC cycle.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input int gap);
        send_byte(a);
        repeat (gap) @(negedge clk);
        send_byte(b);
        repeat (gap) @(negedge clk);
        send_byte(opb);
    endtask

    task automatic expect_pulse(input string name, input logic [7:0] exp,
                                input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        check({name, " exec tx_start"}, tx_start, 1'b0);
        check({name, " exec busy"}, busy, 1'b1);
        @(negedge clk);
        check({name, " tx_start"}, tx_start, 1'b1);
        check({name, " tx_data"}, tx_data, exp);
        check({name, " dato_a"}, dato_a, a);
        check({name, " dato_b"}, dato_b, b);
        check({name, " opcode"}, opcode, op);
        @(negedge clk);
        check({name, " tx_start one cycle"}, tx_start, 1'b0);
        check({name, " busy wait_tx"}, busy, 1'b1);
    endtask

    task automatic close_tx(input string name);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({name, " busy after tx_done"}, busy, 1'b0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"add",      8'h08, 8'h02, 8'h20, 8'd10});
        vecs.push_back('{"sub",      8'h08, 8'h02, 8'h22, 8'd6});
        vecs.push_back('{"or",       8'h03, 8'h01, 8'h25, 8'd3});
        vecs.push_back('{"xor",      8'h03, 8'h01, 8'h26, 8'd2});
        vecs.push_back('{"nor",      8'h03, 8'h01, 8'h27, 8'd252});
        vecs.push_back('{"and",      8'hF0, 8'h3C, 8'h24, 8'h30});
        vecs.push_back('{"srl",      8'h83, 8'h01, 8'h02, 8'd65});
        vecs.push_back('{"sra",      8'h83, 8'h01, 8'h03, 8'd193});
        vecs.push_back('{"add hi",   8'h05, 8'h07, 8'hE0, 8'd12});
`ifdef ALU_IF_OPCODE_CHECK_EN
        vecs.push_back('{"bad op",   8'h08, 8'h02, 8'h3F, 8'hFF});
`else
        vecs.push_back('{"bad op",   8'h08, 8'h02, 8'h3F, 8'h82});
`endif

        reset   = 1'b1;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dato_a", dato_a, 8'h00);
        check("reset dato_b", dato_b, 8'h00);
        check("reset opcode", opcode, 6'h00);
        check("reset tx_data", tx_data, 8'h00);
        check("reset tx_start", tx_start, 1'b0);
        check("reset busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].opb, 0);
            expect_pulse(vecs[i].name, vecs[i].exp, vecs[i].a, vecs[i].b, vecs[i].opb[5:0]);
            close_tx(vecs[i].name);
        end

        // Byte arriving during WAIT_TX is dropped.
        start_op(8'h08, 8'h02, 8'h20, 1);
        expect_pulse("drop", 8'd10, 8'h08, 8'h02, 6'h20);
        send_byte(8'h55);
        check("drop dato_a", dato_a, 8'h08);
        check("drop tx_data", tx_data, 8'd10);
        check("drop busy", busy, 1'b1);
        close_tx("drop");

        // tx_done in WAIT_A is ignored; the next sequence still starts with A.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle tx_done busy", busy, 1'b0);
        start_op(8'h09, 8'h04, 8'h22, 0);
        expect_pulse("after idle tx_done", 8'd5, 8'h09, 8'h04, 6'h22);
        close_tx("after idle tx_done");

        // tx_done sampled while still in EXEC is not seen.
        start_op(8'h01, 8'h01, 8'h20, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("exec tx_done pulse", tx_start, 1'b1);
        @(negedge clk);
        check("exec tx_done busy", busy, 1'b1);
        close_tx("exec tx_done");

        // Asynchronous reset after A only.
        send_byte(8'h08);
        #2 reset = 1'b1;
        #1;
        check("rst after a dato_a", dato_a, 8'h00);
        check("rst after a opcode", opcode, 6'h00);
        check("rst after a tx_data", tx_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        start_op(8'h03, 8'h01, 8'h26, 0);
        expect_pulse("post rst a", 8'd2, 8'h03, 8'h01, 6'h26);
        close_tx("post rst a");

        // Asynchronous reset while the tx_start pulse is high.
        start_op(8'h08, 8'h02, 8'h20, 0);
        @(negedge clk);
        check("rst tx pulse high", tx_start, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst tx tx_start", tx_start, 1'b0);
        check("rst tx tx_data", tx_data, 8'h00);
        check("rst tx dato_b", dato_b, 8'h00);
        check("rst tx busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        start_op(8'h08, 8'h02, 8'h20, 0);
        expect_pulse("post rst tx", 8'd10, 8'h08, 8'h02, 6'h20);
        close_tx("post rst tx");

        // Randomized sequences against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b, opb;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0) opb = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
            else                           opb = 8'($urandom);
            start_op(a, b, opb, $urandom_range(0, 2));
            expect_pulse("rand", expected_reply(a, b, opb), a, b, opb[5:0]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand tx_data hold", tx_data, expected_reply(a, b, opb));
            close_tx("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
